// File: rtl/btn_evt_pkg.sv
// Shared state encodings and constants for the button event arbiter.
package btn_evt_pkg;

  typedef enum logic [1:0] {
    F_IDLE  = 2'd0,
    F_COUNT = 2'd1,
    F_HELD  = 2'd2
  } filt_state_e;

  typedef enum logic {
    A_IDLE  = 1'b0,
    A_OFFER = 1'b1
  } arb_state_e;

  localparam logic [7:0] DROP_MAX = 8'd255;

endpackage

// File: rtl/btn_hold_filter.sv
// Hold filter for one button: emits a single-cycle pulse once the button has
// been sampled high HOLD_CYC times in a row, then waits for release.
module btn_hold_filter
  import btn_evt_pkg::*;
#(
  parameter int HOLD_CYC = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam int CNT_W = (HOLD_CYC < 2) ? 1 : $clog2(HOLD_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYC - 1);

  filt_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    case (state_q)
      F_IDLE: begin
        if (btn) begin
          if (HOLD_CYC == 1) begin
            pulse_d = 1'b1;
            state_d = F_HELD;
          end else begin
            cnt_d   = CNT_W'(1);
            state_d = F_COUNT;
          end
        end
      end
      F_COUNT: begin
        if (!btn) begin
          state_d = F_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          pulse_d = 1'b1;
          state_d = F_HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      F_HELD: begin
        if (!btn) state_d = F_IDLE;
      end
      default: state_d = F_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= F_IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/btn_event_arbiter.sv
// Filters N_BTN buttons, latches accepted presses as sticky requests and
// serialises them round-robin onto a valid/ready event port.
module btn_event_arbiter
  import btn_evt_pkg::*;
#(
  parameter int N_BTN    = 4,
  parameter int HOLD_CYC = 3,
  parameter int ID_W     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [ID_W-1:0]  evt_id,
  output logic [N_BTN-1:0] pending,
  output logic [7:0]       drop_cnt
);

  logic [N_BTN-1:0] pulse;

  generate
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_filt
      btn_hold_filter #(.HOLD_CYC(HOLD_CYC)) u_filt (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn[gi]),
        .pulse (pulse[gi])
      );
    end
  endgenerate

  arb_state_e       arb_q, arb_d;
  logic             valid_q, valid_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [N_BTN-1:0] pending_q, pending_d;
  logic [7:0]       drop_q, drop_d;

  logic             hs;
  logic [N_BTN-1:0] clr;
  logic [N_BTN-1:0] lost;
  logic             found;
  logic [ID_W-1:0]  sel;
  int               idx;

  // A pulse landing on the clear edge of the same button wins: the new press is kept.
  always_comb begin
    hs = (arb_q == A_OFFER) && evt_ready;
    clr = '0;
    if (hs) clr[id_q] = 1'b1;
    lost      = pulse & pending_q & ~clr;
    pending_d = (pending_q & ~clr) | pulse;
    drop_d    = drop_q;
    if ((|lost) && (drop_q != DROP_MAX)) drop_d = drop_q + 8'd1;
  end

  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int k = 0; k < N_BTN; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_BTN) idx = idx - N_BTN;
      if (!found && pending_q[idx]) begin
        found = 1'b1;
        sel   = ID_W'(idx);
      end
    end
  end

  always_comb begin
    arb_d   = arb_q;
    valid_d = valid_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    case (arb_q)
      A_IDLE: begin
        if (found) begin
          id_d    = sel;
          valid_d = 1'b1;
          arb_d   = A_OFFER;
        end
      end
      A_OFFER: begin
        if (evt_ready) begin
          valid_d = 1'b0;
          arb_d   = A_IDLE;
          ptr_d   = (id_q == ID_W'(N_BTN - 1)) ? '0 : id_q + ID_W'(1);
        end
      end
      default: arb_d = A_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      arb_q     <= A_IDLE;
      valid_q   <= 1'b0;
      id_q      <= '0;
      ptr_q     <= '0;
      pending_q <= '0;
      drop_q    <= '0;
    end else begin
      arb_q     <= arb_d;
      valid_q   <= valid_d;
      id_q      <= id_d;
      ptr_q     <= ptr_d;
      pending_q <= pending_d;
      drop_q    <= drop_d;
    end
  end

  assign evt_valid = valid_q;
  assign evt_id    = id_q;
  assign pending   = pending_q;
  assign drop_cnt  = drop_q;

endmodule
